// File: rtl/pll_recfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_recfg_pkg
// Description : Shared types and reconfiguration register map for the PLL
//               reconfiguration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_recfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_GAP  = 3'd2,
        ST_PRST = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

    // Reconfiguration port register addresses
    localparam logic [5:0] MODE  = 6'd0;
    localparam logic [5:0] APPLY = 6'd2;
    localparam logic [5:0] N     = 6'd3;
    localparam logic [5:0] M     = 6'd4;
    localparam logic [5:0] C0    = 6'd5;
    localparam logic [5:0] K     = 6'd7;
    localparam logic [5:0] BW    = 6'd8;
    localparam logic [5:0] CP    = 6'd9;

    localparam logic [31:0] N_VAL  = 32'h0001_0000;
    localparam logic [31:0] CP_VAL = 32'd1;
    localparam logic [31:0] BW_VAL = 32'd7;

    function automatic logic [5:0] step_addr(input logic [2:0] step);
        case (step)
            3'd0:    return MODE;
            3'd1:    return M;
            3'd2:    return K;
            3'd3:    return N;
            3'd4:    return C0;
            3'd5:    return CP;
            3'd6:    return BW;
            default: return APPLY;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_recfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_recfg_seq
// Description : Issues the eight-write PLL reconfiguration sequence over the
//               Avalon-MM mgmt port, pulses PLL reset and waits for lock.
//               Define PLL_RECFG_LOCK_TIMEOUT_EN to enable the lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_recfg_seq
    import pll_recfg_pkg::*;
#(
    parameter int STEP_GAP     = 8,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] m_val,
    input  logic [31:0] k_val,
    input  logic [31:0] c0_val,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        pll_reset
);

    localparam int c_gap_w = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((STEP_GAP > 1) ? STEP_GAP - 2 : 0);
    localparam int c_rst_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_step, w_step_nxt;
    logic [c_gap_w-1:0]   r_gap_cnt, w_gap_nxt;
    logic [c_rst_w-1:0]   r_rst_cnt, w_rst_nxt;
    logic [1:0]           r_blank, w_blank_nxt;
    logic                 r_done, w_done_nxt;
    logic [31:0]          r_m, r_k, r_c0;
    logic                 r_lock_meta, r_lock_sync;
    logic                 w_accept;
    logic [31:0]          w_step_data;

`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
    localparam int c_to_w = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(LOCK_TIMEOUT - 1);
    logic                 r_error, w_error_nxt;
    logic [c_to_w-1:0]    r_lock_cnt, w_lock_nxt;
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // A start coinciding with the done/error pulse is deliberately dropped
    assign w_accept = (r_state == ST_IDLE) && start && !done && !error;

    always_comb begin
        case (r_step)
            3'd1:    w_step_data = r_m;
            3'd2:    w_step_data = r_k;
            3'd3:    w_step_data = N_VAL;
            3'd4:    w_step_data = r_c0;
            3'd5:    w_step_data = CP_VAL;
            3'd6:    w_step_data = BW_VAL;
            default: w_step_data = 32'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_gap_nxt   = r_gap_cnt;
        w_rst_nxt   = r_rst_cnt;
        w_blank_nxt = r_blank;
        w_done_nxt  = 1'b0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
        w_error_nxt = 1'b0;
        w_lock_nxt  = r_lock_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WR;
                    w_step_nxt  = 3'd0;
                end
            end
            ST_WR: begin
                if (!mgmt_waitrequest) begin
                    w_gap_nxt = '0;
                    if (STEP_GAP > 1) begin
                        w_state_nxt = ST_GAP;
                    end else if (r_step == 3'd7) begin
                        w_state_nxt = ST_PRST;
                        w_rst_nxt   = '0;
                    end else begin
                        w_step_nxt = r_step + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    if (r_step == 3'd7) begin
                        w_state_nxt = ST_PRST;
                        w_rst_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_WR;
                        w_step_nxt  = r_step + 3'd1;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + c_gap_w'(1);
                end
            end
            ST_PRST: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_state_nxt = ST_LOCK;
                    w_blank_nxt = 2'd0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
                    w_lock_nxt  = '0;
`endif
                end else begin
                    w_rst_nxt = r_rst_cnt + c_rst_w'(1);
                end
            end
            ST_LOCK: begin
                // The first two LOCK cycles may still see lock from before PLL reset
                if ((r_blank == 2'd2) && r_lock_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    if (r_blank != 2'd2) w_blank_nxt = r_blank + 2'd1;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
                    if (r_lock_cnt == c_to_last) begin
                        w_state_nxt = ST_IDLE;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_lock_nxt = r_lock_cnt + c_to_w'(1);
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step      <= 3'd0;
            r_gap_cnt   <= '0;
            r_rst_cnt   <= '0;
            r_blank     <= 2'd0;
            r_done      <= 1'b0;
            r_m         <= 32'd0;
            r_k         <= 32'd0;
            r_c0        <= 32'd0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
            r_error     <= 1'b0;
            r_lock_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_rst_cnt   <= w_rst_nxt;
            r_blank     <= w_blank_nxt;
            r_done      <= w_done_nxt;
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
            r_error     <= w_error_nxt;
            r_lock_cnt  <= w_lock_nxt;
`endif
            if (w_accept) begin
                r_m  <= m_val;
                r_k  <= k_val;
                r_c0 <= c0_val;
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign mgmt_write     = (r_state == ST_WR);
    assign mgmt_address   = mgmt_write ? step_addr(r_step) : 6'd0;
    assign mgmt_writedata = mgmt_write ? w_step_data : 32'd0;
    assign pll_reset      = (r_state == ST_PRST);

endmodule
`default_nettype wire

// File: doc/pll_recfg_seq.md
# pll_recfg_seq

Sequencer that reprograms the SDRAM test clock PLL through its Avalon-MM reconfiguration (mgmt) port. It is the stage directly upstream of `pll_cfg`/`pll`. It accepts one set of M/K/C0 counter words per request, issues the fixed eight-write reconfiguration sequence, pulses the PLL reset and waits for lock. The memtest frequency stepper (keyboard/joystick/auto-step logic) drives it on `CLK_50M`.

## Interface
Parameters:
- `STEP_GAP`, 8: cycles from one accepted write to the next write's assertion; minimum 1.
- `RST_CYCLES`, 8: cycles `pll_reset` is held high; minimum 1.
- `LOCK_TIMEOUT`, 50000000: cycles to wait for lock. Used only with the timeout macro.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, `CLK_50M` domain.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request. Ignored unless state is IDLE.
- `m_val` in 32: M counter word, latched on accepted `start`.
- `k_val` in 32: K fractional word, latched on accepted `start`.
- `c0_val` in 32: C0 counter word, latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done` or `error`.
- `done` out 1: one-cycle pulse when lock is achieved.
- `error` out 1: one-cycle pulse on lock timeout.
- `mgmt_address` out 6: reconfig register address.
- `mgmt_writedata` out 32: reconfig write data.
- `mgmt_write` out 1: Avalon write strobe.
- `mgmt_waitrequest` in 1: Avalon wait.
- `pll_locked` in 1: PLL lock. Asynchronous; synchronised internally with 2 flops.
- `pll_reset` out 1: PLL reset request.

## Operation
- States: IDLE, WR, GAP, PRST, LOCK.
- Step table, indexed 0..7 as (address, data):
  - 0: (0, 0), mode
  - 1: (4, M)
  - 2: (7, K)
  - 3: (3, 'h10000), N
  - 4: (5, C0)
  - 5: (9, 1), charge pump
  - 6: (8, 7), bandwidth
  - 7: (2, 0), apply
- IDLE → WR on `start`. Latch M/K/C0 and set step = 0.
- WR:
  - `mgmt_write` = 1, with address and data from the table.
  - Transfer completes in the first cycle where `mgmt_waitrequest` = 0. The next state is then GAP. Address and data stay stable while waiting.
- GAP:
  - Counts `STEP_GAP`-1 cycles.
  - At the end: if step < 7, increment step and return to WR; else go to PRST.
- PRST: `pll_reset` = 1 for exactly `RST_CYCLES` cycles, then go to LOCK.
- LOCK:
  - Wait for synchronised `pll_locked` = 1, then pulse `done` and return to IDLE.
  - Locked is ignored for the first 2 LOCK cycles so a stale lock through the synchroniser is not accepted.
- `start` while not IDLE: ignored; latched values are unchanged.
- `start` in the same cycle that `done` or `error` pulses: ignored. It is accepted on the next IDLE cycle.
- Reset at any point, including mid-write or while `pll_reset` is high:
  - Returns to IDLE immediately.
  - All outputs go to 0, including `pll_reset` and `mgmt_write`.
  - The interrupted sequence is not resumed.
- Reset values: `busy`, `done`, `error`, `mgmt_write`, `pll_reset` = 0; `mgmt_address` = 0; `mgmt_writedata` = 0; step = 0.

## Timing
- `start` is sampled at edge t. `busy` = 1 and `mgmt_write` = 1 with address 0 from t+1.
- Write accepted at edge a: `mgmt_write` = 0 from a+1. The next write is asserted at a+`STEP_GAP`.
- With `mgmt_waitrequest` held 0:
  - Last write accepted at t+1+7·`STEP_GAP`.
  - `pll_reset` high for cycles t+1+8·`STEP_GAP` … +`RST_CYCLES`-1.
- `done` asserts no earlier than 3 cycles after raw `pll_locked` rises: 2 synchroniser cycles plus the registered output. `busy` falls in the same cycle `done` is high.
- Counters are sized by `$clog2` of their parameter. The gap counter is saturating; it does not wrap.

## Configuration
- `PLL_RECFG_LOCK_TIMEOUT_EN` defined:
  - The LOCK counter runs.
  - After `LOCK_TIMEOUT` cycles without lock: pulse `error`, drop `busy`, return to IDLE with `pll_reset` = 0.
- Undefined:
  - No counter; LOCK waits indefinitely.
  - `error` is tied to 0.

## Structure
- Package `pll_recfg_pkg` contains:
  - State enum.
  - Address localparams (MODE=0, APPLY=2, N=3, M=4, C0=5, BW=8, CP=9, K=7).
  - Constants N_VAL='h10000, CP_VAL=1, BW_VAL=7.
  - Function `step_addr(step)`.
- Single flat module; the two-flop lock synchroniser is inline. No sub-module is warranted.

## Test plan
- Nominal: `start` with M='h167, K='h00808, C0='h20302, `waitrequest` = 0 → eight writes in table order with addresses 0,4,7,3,5,9,8,2 and data 0,'h167,'h808,'h10000,'h20302,1,7,0, spaced 8 cycles; `pll_reset` high for 8 cycles; lock raised 10 cycles later → `done` pulse, `busy` falls.
- Waitrequest: hold `waitrequest` = 1 for 5 cycles on step 2 → `mgmt_write`, address 7 and data 'h808 stay stable for 6 cycles; the following write comes 8 cycles after acceptance.
- Ignored start: pulse `start` with M='h70 during step 4 → `m_val` latch still 'h167; only one sequence runs.
- Reset mid-PRST: assert `reset` while `pll_reset` = 1 → all outputs 0 immediately; a new `start` restarts from step 0.
- Stale lock: `pll_locked` held 1 throughout → `done` still requires the full sequence plus the 2-cycle blanking; no early `done`.
- Timeout (macro defined, `LOCK_TIMEOUT` = 100): lock never rises → `error` pulses 100 cycles into LOCK, `busy` = 0, `done` never pulses.
